// File: rtl/pulse_cmd_decoder.sv
// ---------------------------------------------------------------------------
// pulse_cmd_decoder
//   Decodes framed UART commands that program the pulse generator timing
//   registers, and answers each complete frame with an ACK/NAK byte.
//
//   Frame: 0xA5, addr, D0, D1, D2, D3 (LSB first), csum
//          csum = addr ^ D0 ^ D1 ^ D2 ^ D3
//   Address map: 0 period, 1 p1_width, 2 delay, 3 p2_width, 4 ctrl[15:0]
//
//   Accepted writes land in a shadow bank first. The shadow bank is copied
//   to the active outputs at the next period_start, or on the following
//   cycle when the generator is not running (ctrl[0] == 0).
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   rx_data, rx_valid   received UART byte and its one-cycle strobe
//   period_start        one-cycle strobe at each Sync period boundary
//   period, p1_width,
//   delay, p2_width     active timing registers
//   ctrl                active control: [0] run, [1] cpmg_mode, [15:8] cpmg_count
//   tx_data, tx_valid,
//   tx_ready            response byte handshake (0x06 ACK / 0x15 NAK)
//   pending             shadow values waiting to be applied
// ---------------------------------------------------------------------------
module pulse_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter logic [31:0] PERIOD_RST     = 32'd600000,
  parameter logic [31:0] P1_RST         = 32'd30,
  parameter logic [31:0] P2_RST         = 32'd60,
  parameter logic [31:0] DELAY_RST      = 32'd200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        period_start,
  output logic [31:0] period,
  output logic [31:0] p1_width,
  output logic [31:0] delay,
  output logic [31:0] p2_width,
  output logic [15:0] ctrl,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        pending
);

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [7:0]  ACK_BYTE  = 8'h06;
  localparam logic [7:0]  NAK_BYTE  = 8'h15;
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_D0,
    S_D1,
    S_D2,
    S_D3,
    S_CSUM
  } state_t;

  state_t      state;
  logic [31:0] to_cnt;
  logic [7:0]  addr_r;
  logic [7:0]  csum_r;
  logic [31:0] data_r;

  logic [31:0] sh_period;
  logic [31:0] sh_p1_width;
  logic [31:0] sh_delay;
  logic [31:0] sh_p2_width;
  logic [15:0] sh_ctrl;

  logic        frame_done;
  logic        csum_ok;
  logic        addr_ok;
  logic        commit;
  logic        apply;
  logic [7:0]  resp_byte;

  always_comb begin
    frame_done = rx_valid && (state == S_CSUM);
    csum_ok    = (csum_r == rx_data);
    addr_ok    = (addr_r < 8'd5);
    commit     = frame_done && csum_ok && addr_ok;
    // Shadows move to active on a period boundary, or immediately when the
    // generator is stopped so a paused system never waits for a strobe.
    apply      = pending && (period_start || !ctrl[0]);
    resp_byte  = (csum_ok && addr_ok) ? ACK_BYTE : NAK_BYTE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      to_cnt      <= '0;
      addr_r      <= '0;
      csum_r      <= '0;
      data_r      <= '0;
      sh_period   <= PERIOD_RST;
      sh_p1_width <= P1_RST;
      sh_delay    <= DELAY_RST;
      sh_p2_width <= P2_RST;
      sh_ctrl     <= '0;
      period      <= PERIOD_RST;
      p1_width    <= P1_RST;
      delay       <= DELAY_RST;
      p2_width    <= P2_RST;
      ctrl        <= '0;
      pending     <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
    end else begin
      // Frame receiver and inter-byte timeout
      if (rx_valid) begin
        to_cnt <= '0;
        case (state)
          S_IDLE: if (rx_data == SYNC_BYTE) state <= S_ADDR;
          S_ADDR: begin
            addr_r <= rx_data;
            csum_r <= rx_data;
            state  <= S_D0;
          end
          S_D0: begin
            data_r[7:0] <= rx_data;
            csum_r      <= csum_r ^ rx_data;
            state       <= S_D1;
          end
          S_D1: begin
            data_r[15:8] <= rx_data;
            csum_r       <= csum_r ^ rx_data;
            state        <= S_D2;
          end
          S_D2: begin
            data_r[23:16] <= rx_data;
            csum_r        <= csum_r ^ rx_data;
            state         <= S_D3;
          end
          S_D3: begin
            data_r[31:24] <= rx_data;
            csum_r        <= csum_r ^ rx_data;
            state         <= S_CSUM;
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        if (to_cnt == TO_LAST) begin
          state  <= S_IDLE;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 32'd1;
        end
      end else begin
        to_cnt <= '0;
      end

      // Shadow write on an accepted frame
      if (commit) begin
        case (addr_r[2:0])
          3'd0:    sh_period   <= data_r;
          3'd1:    sh_p1_width <= data_r;
          3'd2:    sh_delay    <= data_r;
          3'd3:    sh_p2_width <= data_r;
          3'd4:    sh_ctrl     <= data_r[15:0];
          default: ;
        endcase
      end

      // Apply uses the shadows as they were before this edge; a commit on
      // the same edge therefore stays pending for the next boundary.
      if (apply) begin
        period   <= sh_period;
        p1_width <= sh_p1_width;
        delay    <= sh_delay;
        p2_width <= sh_p2_width;
        ctrl     <= sh_ctrl;
        pending  <= 1'b0;
      end
      if (commit) pending <= 1'b1;

      // Single-entry response slot; a response arriving while the slot is
      // occupied is discarded, even on the cycle the slot is being drained.
      if (tx_valid) begin
        if (tx_ready) tx_valid <= 1'b0;
      end else if (frame_done) begin
        tx_valid <= 1'b1;
        tx_data  <= resp_byte;
      end
    end
  end

endmodule

// File: tb/tb_pulse_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_pulse_cmd_decoder
//   Directed-vector bench for pulse_cmd_decoder with hand-computed frames,
//   checksums and expected register values.
// ---------------------------------------------------------------------------
module tb_pulse_cmd_decoder;

  localparam int unsigned TO = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        period_start = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] period, p1_width, delay, p2_width;
  logic [15:0] ctrl;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        pending;

  int n_tests = 0;
  int n_fail  = 0;

  pulse_cmd_decoder #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .period_start(period_start),
    .period(period),
    .p1_width(p1_width),
    .delay(delay),
    .p2_width(p2_width),
    .ctrl(ctrl),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ps);
    rx_data      = b;
    rx_valid     = 1'b1;
    period_start = ps;
    tick(1);
    rx_valid     = 1'b0;
    period_start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3, input logic [7:0] cs,
                            input logic ps_on_csum);
    send_byte(8'hA5, 1'b0);
    send_byte(a, 1'b0);
    send_byte(d0, 1'b0);
    send_byte(d1, 1'b0);
    send_byte(d2, 1'b0);
    send_byte(d3, 1'b0);
    send_byte(cs, ps_on_csum);
  endtask

  // Checks an outstanding response, holds it with tx_ready low, then drains it.
  task automatic expect_resp(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(tx_valid), 32'd1);
    check({tag, "_data"}, 32'(tx_data), 32'(exp));
    tick(2);
    check({tag, "_hold_valid"}, 32'(tx_valid), 32'd1);
    check({tag, "_hold_data"}, 32'(tx_data), 32'(exp));
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
    check({tag, "_drop"}, 32'(tx_valid), 32'd0);
  endtask

  task automatic pulse_ps();
    period_start = 1'b1;
    tick(1);
    period_start = 1'b0;
  endtask

  initial begin
    // Reset values
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_period", period, 32'd600000);
    check("rst_p1", p1_width, 32'd30);
    check("rst_delay", delay, 32'd200);
    check("rst_p2", p2_width, 32'd60);
    check("rst_ctrl", 32'(ctrl), 32'h0);
    check("rst_txv", 32'(tx_valid), 32'd0);
    check("rst_txd", 32'(tx_data), 32'h0);
    check("rst_pend", 32'(pending), 32'd0);

    // run=0: p1_width write applies one cycle after the commit
    send_frame(8'h01, 8'h40, 8'h00, 8'h00, 8'h00, 8'h41, 1'b0);
    check("p1_commit_pend", 32'(pending), 32'd1);
    check("p1_not_yet", p1_width, 32'd30);
    tick(1);
    check("p1_applied", p1_width, 32'h40);
    check("p1_pend_clr", 32'(pending), 32'd0);
    expect_resp("p1_ack", 8'h06);

    // Non-sync bytes in IDLE produce nothing
    send_byte(8'h55, 1'b0);
    send_byte(8'h00, 1'b0);
    tick(3);
    check("idle_junk_txv", 32'(tx_valid), 32'd0);

    // ctrl = 0x0301 (run=1, cpmg_count=3)
    send_frame(8'h04, 8'h01, 8'h03, 8'h00, 8'h00, 8'h06, 1'b0);
    tick(1);
    check("ctrl_applied", 32'(ctrl), 32'h0301);
    expect_resp("ctrl_ack", 8'h06);

    // run=1: period waits for period_start
    send_frame(8'h00, 8'h10, 8'h27, 8'h00, 8'h00, 8'h37, 1'b0);
    expect_resp("per_ack", 8'h06);
    tick(3);
    check("per_held", period, 32'd600000);
    check("per_pend", 32'(pending), 32'd1);
    pulse_ps();
    check("per_applied", period, 32'd10000);
    check("per_pend_clr", 32'(pending), 32'd0);

    // Bad checksum and invalid address are NAKed without side effects
    send_frame(8'h02, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    expect_resp("badcs_nak", 8'h15);
    check("badcs_pend", 32'(pending), 32'd0);
    pulse_ps();
    check("badcs_delay", delay, 32'd200);
    send_frame(8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 1'b0);
    expect_resp("badaddr_nak", 8'h15);
    check("badaddr_pend", 32'(pending), 32'd0);

    // Response while slot busy is dropped but the write still happens
    send_frame(8'h02, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    send_frame(8'h03, 8'h50, 8'h00, 8'h00, 8'h00, 8'h53, 1'b0);
    check("drop_pend", 32'(pending), 32'd1);
    expect_resp("drop_keeps_nak", 8'h15);
    tick(2);
    check("drop_no_second", 32'(tx_valid), 32'd0);
    pulse_ps();
    check("drop_p2_written", p2_width, 32'h50);

    // Gap just under the timeout keeps the frame alive
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    tick(TO - 2);
    send_byte(8'h23, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h20, 1'b0);
    expect_resp("gap_ok_ack", 8'h06);
    pulse_ps();
    check("gap_ok_delay", delay, 32'h123);

    // Timeout aborts a partial frame silently
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    tick(TO + 2);
    check("to_txv", 32'(tx_valid), 32'd0);
    check("to_pend", 32'(pending), 32'd0);
    send_frame(8'h03, 8'h44, 8'h00, 8'h00, 8'h00, 8'h47, 1'b0);
    expect_resp("to_after_ack", 8'h06);
    pulse_ps();
    check("to_after_p2", p2_width, 32'h44);

    // Commit coinciding with period_start defers to the next boundary
    send_frame(8'h01, 8'h77, 8'h00, 8'h00, 8'h00, 8'h76, 1'b1);
    check("coin_p1_held", p1_width, 32'h40);
    check("coin_pend", 32'(pending), 32'd1);
    expect_resp("coin_ack", 8'h06);
    check("coin_p1_still", p1_width, 32'h40);
    pulse_ps();
    check("coin_p1_applied", p1_width, 32'h77);

    // Reset during D2 discards the frame
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    reset = 1'b1;
    #2;
    check("mid_rst_ctrl", 32'(ctrl), 32'h0);
    tick(2);
    reset = 1'b0;
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h05, 1'b0);
    tick(3);
    check("mid_rst_txv", 32'(tx_valid), 32'd0);
    check("mid_rst_period", period, 32'd600000);
    check("mid_rst_p1", p1_width, 32'd30);
    check("mid_rst_delay", delay, 32'd200);
    check("mid_rst_p2", p2_width, 32'd60);
    check("mid_rst_pend", 32'(pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
